exec_ctrl: RTL and testbench
============================

Name: exec_ctrl

Overview:
- Multi-cycle execute controller that sequences the register-file/ALU datapath (alu_top) one instruction at a time.
- Accepts a decoded instruction over a valid/ready handshake and drives the datapath controls: register addresses, reg write, write-source select, ALU source, ALU op.
- Runs a memory request/acknowledge exchange for loads and stores, with a timeout.
- Resolves branches from the datapath equal flag.

Parameters:
- ADDR_WIDTH, 5, register address width.
- MEM_TIMEOUT, 16, maximum MEM_WAIT cycles before error.
- CNT_WIDTH, $clog2(MEM_TIMEOUT+1), wait counter width (derived, not overridden).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- instr_valid_i  in  1  decoded instruction valid.
- instr_ready_o  out  1  controller can accept an instruction.
- dec_class_i  in  2  instruction class: 00 ALU, 01 LOAD, 10 STORE, 11 BRANCH.
- dec_rs1_i / dec_rs2_i / dec_rd_i  in  ADDR_WIDTH each  decoded register addresses.
- dec_alu_ctrl_i  in  4  decoded ALU operation.
- dec_alu_src_i  in  1  decoded ALU source: 0 = rs2, 1 = immediate.
- eq_i  in  1  datapath equal flag.
- mem_ack_i  in  1  memory access complete.
- rs1_o / rs2_o / rd_o  out  ADDR_WIDTH each  datapath register addresses.
- reg_write_o  out  1  register write enable.
- reg_write_src_o  out  1  write-source select: 0 = ALU, 1 = memory.
- alu_src_o  out  1  ALU source select.
- alu_ctrl_o  out  4  ALU operation.
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  memory write (store).
- branch_taken_o  out  1  one-cycle pulse, branch taken.
- retire_o  out  1  one-cycle pulse, instruction complete.
- err_o  out  1  sticky memory timeout error.

Behaviour:
- States: IDLE, EXEC, MEM_WAIT, WB, ERROR.
- Reset (async, rst_ni=0): state = IDLE, all captured fields = 0, counter = 0, err_o = 0.
  - Under reset all outputs are 0 except instr_ready_o, which is 1.
  - Reset mid-instruction abandons the instruction with no write and no retire.
- IDLE:
  - instr_ready_o = 1.
  - On instr_valid_i, capture all dec_* fields at the clock edge, then go to EXEC.
- EXEC:
  - rs1_o, rs2_o, rd_o, alu_src_o, alu_ctrl_o driven from the captured registers.
  - ALU class: reg_write_o = 1, reg_write_src_o = 0, retire_o = 1, then IDLE.
  - LOAD/STORE: alu_src_o forced to 1, alu_ctrl_o forced to ALU_ADD; counter cleared; then MEM_WAIT.
  - BRANCH: branch_taken_o = eq_i, retire_o = 1, then IDLE.
- MEM_WAIT:
  - mem_req_o = 1; mem_we_o = 1 for STORE.
  - ALU controls held, so the datapath address stays stable.
  - Counter increments each cycle without ack.
  - On mem_ack_i, LOAD goes to WB; STORE asserts retire_o and goes to IDLE.
  - If the counter reaches MEM_TIMEOUT-1 with no ack, go to ERROR.
  - mem_ack_i is ignored in every other state.
- WB: reg_write_o = 1, reg_write_src_o = 1, retire_o = 1, then IDLE.
- ERROR: err_o = 1, instr_ready_o = 0. Exit only by reset.
- reg_write_o is forced to 0 whenever the captured rd = 0; retire_o is still asserted.
- Outputs outside the listed assignments are 0.
- instr_ready_o = 0 in every state except IDLE.
- Latency from accept to retire:
  - ALU and BRANCH: 1 cycle after accept.
  - STORE: ack cycle.
  - LOAD: ack cycle + 1.
- Back-to-back instructions: the next one is accepted in the IDLE cycle following retire. Throughput is at most one instruction per 2 cycles.

Decomposition:
- exec_ctrl_pkg holds:
  - state_t enum.
  - instr_class_t enum: CLS_ALU, CLS_LOAD, CLS_STORE, CLS_BRANCH.
  - ALU_ADD = 4'b0000.
- No sub-modules: a single FSM plus capture registers and the wait counter.

Test Plan:
- ALU op: valid with class=ALU, rs1=1, rs2=2, rd=3, alu_ctrl=0 → next cycle reg_write_o=1, rd_o=3, reg_write_src_o=0, retire_o=1; then instr_ready_o=1.
- LOAD with ack after 3 cycles (rd=5) → mem_req_o high for 3 cycles with mem_we_o=0, alu_ctrl_o=0000 and alu_src_o=1 held; then WB cycle with reg_write_o=1, reg_write_src_o=1, retire_o=1.
- STORE with ack on the first MEM_WAIT cycle → mem_we_o=1, retire_o on that cycle, reg_write_o never asserted.
- BRANCH with eq_i=1, then BRANCH with eq_i=0 → branch_taken_o pulses once, then stays 0; retire_o pulses both times.
- LOAD with no ack, MEM_TIMEOUT=16 → err_o=1 after 16 MEM_WAIT cycles; instr_ready_o stays 0; rst_ni low clears to IDLE.
- ALU op with rd=0, plus rst_ni asserted mid-MEM_WAIT → reg_write_o stays 0 while retire_o=1; reset immediately drops mem_req_o and returns to IDLE.

Source files
------------

// File: rtl/exec_ctrl_pkg.sv
// Shared types for the execute controller: FSM states, instruction classes, ALU opcodes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package exec_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_MEM_WAIT,
        S_WB,
        S_ERROR
    } state_t;

    typedef enum logic [1:0] {
        CLS_ALU    = 2'b00,
        CLS_LOAD   = 2'b01,
        CLS_STORE  = 2'b10,
        CLS_BRANCH = 2'b11
    } instr_class_t;

    localparam logic [3:0] ALU_ADD = 4'b0000;

    // Loads and stores share the address-generation and memory-wait path
    function automatic logic is_mem(instr_class_t cls);
        return (cls == CLS_LOAD) || (cls == CLS_STORE);
    endfunction

endpackage

// File: rtl/exec_ctrl.sv
// Multi-cycle execute controller sequencing the register-file/ALU datapath one instruction at a time.
// Latency: ALU/BRANCH retire 1 cycle after accept, STORE on the ack cycle, LOAD one cycle after ack.
// Backpressure: instr_ready_o only in IDLE; memory waits up to MEM_TIMEOUT cycles then locks in ERROR until reset.
module exec_ctrl
    import exec_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH  = 5,
    parameter int MEM_TIMEOUT = 16,
    localparam int CNT_WIDTH  = $clog2(MEM_TIMEOUT + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  instr_valid_i,
    output logic                  instr_ready_o,
    input  logic [1:0]            dec_class_i,
    input  logic [ADDR_WIDTH-1:0] dec_rs1_i,
    input  logic [ADDR_WIDTH-1:0] dec_rs2_i,
    input  logic [ADDR_WIDTH-1:0] dec_rd_i,
    input  logic [3:0]            dec_alu_ctrl_i,
    input  logic                  dec_alu_src_i,
    input  logic                  eq_i,
    input  logic                  mem_ack_i,
    output logic [ADDR_WIDTH-1:0] rs1_o,
    output logic [ADDR_WIDTH-1:0] rs2_o,
    output logic [ADDR_WIDTH-1:0] rd_o,
    output logic                  reg_write_o,
    output logic                  reg_write_src_o,
    output logic                  alu_src_o,
    output logic [3:0]            alu_ctrl_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic                  branch_taken_o,
    output logic                  retire_o,
    output logic                  err_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(MEM_TIMEOUT - 1);

    state_t                state;
    instr_class_t          cls_q;
    logic [ADDR_WIDTH-1:0] rs1_q;
    logic [ADDR_WIDTH-1:0] rs2_q;
    logic [ADDR_WIDTH-1:0] rd_q;
    logic [3:0]            alu_ctrl_q;
    logic                  alu_src_q;
    logic [CNT_WIDTH-1:0]  wait_cnt;

    // FSM, instruction capture and memory-wait counter
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= S_IDLE;
            cls_q      <= CLS_ALU;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            alu_ctrl_q <= '0;
            alu_src_q  <= 1'b0;
            wait_cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (instr_valid_i) begin
                        cls_q      <= instr_class_t'(dec_class_i);
                        rs1_q      <= dec_rs1_i;
                        rs2_q      <= dec_rs2_i;
                        rd_q       <= dec_rd_i;
                        alu_ctrl_q <= dec_alu_ctrl_i;
                        alu_src_q  <= dec_alu_src_i;
                        state      <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    wait_cnt <= '0;
                    state    <= is_mem(cls_q) ? S_MEM_WAIT : S_IDLE;
                end
                S_MEM_WAIT: begin
                    if (mem_ack_i) begin
                        state <= (cls_q == CLS_LOAD) ? S_WB : S_IDLE;
                    end else if (wait_cnt == CNT_LAST) begin
                        state <= S_ERROR;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_WB:    state <= S_IDLE;
                S_ERROR: state <= S_ERROR;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Datapath controls decoded from the current state and captured instruction
    always_comb begin
        instr_ready_o   = 1'b0;
        rs1_o           = '0;
        rs2_o           = '0;
        rd_o            = '0;
        reg_write_o     = 1'b0;
        reg_write_src_o = 1'b0;
        alu_src_o       = 1'b0;
        alu_ctrl_o      = '0;
        mem_req_o       = 1'b0;
        mem_we_o        = 1'b0;
        branch_taken_o  = 1'b0;
        retire_o        = 1'b0;
        err_o           = 1'b0;
        case (state)
            S_IDLE: instr_ready_o = 1'b1;
            S_EXEC: begin
                rs1_o      = rs1_q;
                rs2_o      = rs2_q;
                rd_o       = rd_q;
                alu_src_o  = is_mem(cls_q) ? 1'b1 : alu_src_q;
                alu_ctrl_o = is_mem(cls_q) ? ALU_ADD : alu_ctrl_q;
                if (cls_q == CLS_ALU) begin
                    reg_write_o = (rd_q != '0);
                    retire_o    = 1'b1;
                end
                if (cls_q == CLS_BRANCH) begin
                    branch_taken_o = eq_i;
                    retire_o       = 1'b1;
                end
            end
            S_MEM_WAIT: begin
                // Address-generation controls held so the memory address stays stable
                rs1_o      = rs1_q;
                rs2_o      = rs2_q;
                rd_o       = rd_q;
                alu_src_o  = 1'b1;
                alu_ctrl_o = ALU_ADD;
                mem_req_o  = 1'b1;
                mem_we_o   = (cls_q == CLS_STORE);
                retire_o   = (cls_q == CLS_STORE) && mem_ack_i;
            end
            S_WB: begin
                rd_o            = rd_q;
                reg_write_o     = (rd_q != '0);
                reg_write_src_o = 1'b1;
                retire_o        = 1'b1;
            end
            S_ERROR: err_o = 1'b1;
            default: instr_ready_o = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_exec_ctrl.sv
// Randomised scoreboard bench for exec_ctrl: driver pushes expected retire records, monitor pops on retire_o.
// Latency: expected retire cycle is derived from accept cycle and ack delay.
// Backpressure: driver waits for IDLE between instructions; memory ack delay randomised.
module tb_exec_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       instr_valid;
    logic       instr_ready_o;
    logic [1:0] dec_class;
    logic [4:0] dec_rs1, dec_rs2, dec_rd;
    logic [3:0] dec_alu_ctrl;
    logic       dec_alu_src;
    logic       eq;
    logic       mem_ack;
    logic [4:0] rs1_o, rs2_o, rd_o;
    logic       reg_write_o, reg_write_src_o, alu_src_o;
    logic [3:0] alu_ctrl_o;
    logic       mem_req_o, mem_we_o, branch_taken_o, retire_o, err_o;

    exec_ctrl #(.ADDR_WIDTH(5), .MEM_TIMEOUT(16)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .instr_valid_i   (instr_valid),
        .instr_ready_o   (instr_ready_o),
        .dec_class_i     (dec_class),
        .dec_rs1_i       (dec_rs1),
        .dec_rs2_i       (dec_rs2),
        .dec_rd_i        (dec_rd),
        .dec_alu_ctrl_i  (dec_alu_ctrl),
        .dec_alu_src_i   (dec_alu_src),
        .eq_i            (eq),
        .mem_ack_i       (mem_ack),
        .rs1_o           (rs1_o),
        .rs2_o           (rs2_o),
        .rd_o            (rd_o),
        .reg_write_o     (reg_write_o),
        .reg_write_src_o (reg_write_src_o),
        .alu_src_o       (alu_src_o),
        .alu_ctrl_o      (alu_ctrl_o),
        .mem_req_o       (mem_req_o),
        .mem_we_o        (mem_we_o),
        .branch_taken_o  (branch_taken_o),
        .retire_o        (retire_o),
        .err_o           (err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [4:0] rd;
        logic       wr;
        logic       src;
        logic       bt;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_total = 0;
    int   n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_total++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp_v, $time);
    endtask

    // Monitor: every retire pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (retire_o) begin
                if (sb.size() == 0) begin
                    chk("retire_unexpected", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("retire_cycle", cyc, mon_e.cyc);
                    chk("retire_rd", rd_o, mon_e.rd);
                    chk("retire_reg_write", reg_write_o, mon_e.wr);
                    chk("retire_write_src", reg_write_src_o, mon_e.src);
                    chk("retire_branch_taken", branch_taken_o, mon_e.bt);
                end
            end else begin
                if (reg_write_o) chk("write_without_retire", reg_write_o, 0);
                if (branch_taken_o) chk("branch_without_retire", branch_taken_o, 0);
            end
        end
    end

    // Issue one instruction; d = MEM_WAIT cycle on which ack arrives (loads/stores)
    task automatic issue(input logic [1:0] cls, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic [3:0] ctrl, input logic src,
                         input logic eqv, input int d);
        exp_t e;
        int   acc;
        bit   is_m;
        is_m = (cls == 2'd1) || (cls == 2'd2);
        @(posedge clk); #1;
        chk("ready_in_idle", instr_ready_o, 1);
        dec_class = cls; dec_rs1 = rs1; dec_rs2 = rs2; dec_rd = rd;
        dec_alu_ctrl = ctrl; dec_alu_src = src; eq = eqv;
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        acc = cyc;
        chk("exec_rs1", rs1_o, rs1);
        chk("exec_rs2", rs2_o, rs2);
        chk("exec_alu_ctrl", alu_ctrl_o, is_m ? 4'd0 : ctrl);
        chk("exec_alu_src", alu_src_o, is_m ? 1'b1 : src);
        chk("exec_not_ready", instr_ready_o, 0);
        chk("exec_no_mem_req", mem_req_o, 0);
        e.rd  = rd;
        e.wr  = ((cls == 2'd0) || (cls == 2'd1)) && (rd != 0);
        e.src = (cls == 2'd1);
        e.bt  = (cls == 2'd3) && eqv;
        e.cyc = !is_m ? acc : (cls == 2'd2 ? acc + d : acc + d + 1);
        sb.push_back(e);
        if (is_m) begin
            for (int k = 1; k <= d; k++) begin
                @(posedge clk); #1;
                chk("wait_mem_req", mem_req_o, 1);
                chk("wait_mem_we", mem_we_o, cls == 2'd2);
                chk("wait_alu_ctrl", alu_ctrl_o, 0);
                chk("wait_alu_src", alu_src_o, 1);
                if (k == d) mem_ack = 1'b1;
            end
            @(posedge clk); #1;
            mem_ack = 1'b0;
        end
    endtask

    initial begin
        int n;
        rst_n = 1'b0; instr_valid = 1'b0; dec_class = '0; dec_rs1 = '0; dec_rs2 = '0;
        dec_rd = '0; dec_alu_ctrl = '0; dec_alu_src = 1'b0; eq = 1'b0; mem_ack = 1'b0;
        #1;
        chk("reset_ready", instr_ready_o, 1);
        chk("reset_outputs", {rs1_o, rs2_o, rd_o, reg_write_o, reg_write_src_o, alu_src_o,
                              alu_ctrl_o, mem_req_o, mem_we_o, branch_taken_o, retire_o, err_o}, 0);
        #12;
        @(posedge clk); #1 rst_n = 1'b1;

        // Directed cases
        issue(2'd0, 5'd1, 5'd2, 5'd3, 4'd0, 1'b0, 1'b0, 0);   // ALU rd=3
        issue(2'd1, 5'd4, 5'd0, 5'd5, 4'd7, 1'b0, 1'b0, 3);   // LOAD, ack on 3rd wait cycle
        issue(2'd2, 5'd6, 5'd8, 5'd9, 4'd3, 1'b0, 1'b0, 1);   // STORE, immediate ack
        issue(2'd3, 5'd1, 5'd1, 5'd0, 4'd1, 1'b0, 1'b1, 0);   // BRANCH taken
        issue(2'd3, 5'd1, 5'd2, 5'd0, 4'd1, 1'b0, 1'b0, 0);   // BRANCH not taken
        issue(2'd0, 5'd7, 5'd8, 5'd0, 4'd5, 1'b1, 1'b0, 0);   // ALU rd=0: no write
        issue(2'd1, 5'd2, 5'd3, 5'd0, 4'd2, 1'b1, 1'b0, 2);   // LOAD rd=0: no write
        issue(2'd1, 5'd2, 5'd3, 5'd11, 4'd2, 1'b1, 1'b0, 16); // LOAD ack on last allowed cycle

        // Random traffic
        for (int i = 0; i < 60; i++) begin
            issue(2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                  5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), $urandom_range(1, 6));
        end

        // Reset while a load is waiting on memory
        @(posedge clk); #1;
        dec_class = 2'd1; dec_rd = 5'd7; instr_valid = 1'b1;
        @(posedge clk); #1 instr_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("midwait_req", mem_req_o, 1);
        rst_n = 1'b0;
        #1;
        chk("midwait_reset_req", mem_req_o, 0);
        chk("midwait_reset_ready", instr_ready_o, 1);
        chk("midwait_reset_retire", retire_o, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        issue(2'd0, 5'd1, 5'd2, 5'd3, 4'd4, 1'b0, 1'b0, 0);

        // Timeout: load with no ack ever
        @(posedge clk); #1;
        dec_class = 2'd1; dec_rd = 5'd12; instr_valid = 1'b1;
        @(posedge clk); #1 instr_valid = 1'b0;
        n = 0;
        for (int k = 0; k < 40 && !err_o; k++) begin
            @(posedge clk); #1;
            if (mem_req_o) n++;
        end
        chk("timeout_wait_cycles", n, 16);
        chk("timeout_err", err_o, 1);
        chk("timeout_not_ready", instr_ready_o, 0);
        instr_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        instr_valid = 1'b0;
        chk("error_sticky", err_o, 1);
        chk("error_not_ready", instr_ready_o, 0);
        rst_n = 1'b0;
        #1;
        chk("error_reset_err", err_o, 0);
        chk("error_reset_ready", instr_ready_o, 1);
        @(posedge clk); #1 rst_n = 1'b1;
        issue(2'd2, 5'd3, 5'd4, 5'd5, 4'd0, 1'b0, 1'b0, 2);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
